cam_host_link: RTL

Host-side end of the camera serial command link. Turns operator requests into the single-byte ASCII commands 's', 'd' and 'f', and hands each one to the UART transmitter through the load/transmit handshake. Decodes the status bytes the camera side sends back: 'g', 'h', '-' and digits '0'–'9'. It sits between the host board's buttons/LEDs and its UART transmitter/receiver pair.

---
 rtl/cam_host_link.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cam_host_link.sv
// Host end of the camera serial command link: edge-captured operator requests become
// single-byte commands for the UART transmitter; received status bytes are decoded.
module cam_host_link #(
  parameter logic [7:0] CHAR_START = 8'h73,
  parameter logic [7:0] CHAR_DL1   = 8'h64,
  parameter logic [7:0] CHAR_DL2   = 8'h66
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       startReq,
  input  logic       dl1Req,
  input  logic       dl2Req,
  input  logic [3:0] bicS,
  input  logic [3:0] bicR,
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut,
  output logic       load,
  output logic       transmit,
  output logic       busy,
  output logic       rtd1,
  output logic       rtd2,
  output logic [3:0] progress1,
  output logic [3:0] progress2,
  output logic       rxErr,
  output logic [3:0] errCount
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} txState_t;

  txState_t   state, nextState;
  logic       startQ, dl1Q, dl2Q;
  logic       pendS, pendD1, pendD2;
  logic       clrS, clrD1, clrD2;
  logic [1:0] activeCam, nextCam;
  logic [7:0] nextData;
  logic       fullQ, byteStrobe;
  logic       isDigit, isG, isH, isDash, errHit;

  // Request edge detection and one-deep pending bits; a fresh edge wins over a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      startQ <= 1'b0;
      dl1Q   <= 1'b0;
      dl2Q   <= 1'b0;
      pendS  <= 1'b0;
      pendD1 <= 1'b0;
      pendD2 <= 1'b0;
    end else begin
      startQ <= startReq;
      dl1Q   <= dl1Req;
      dl2Q   <= dl2Req;
      pendS  <= (pendS  & ~clrS)  | (startReq & ~startQ);
      pendD1 <= (pendD1 & ~clrD1) | (dl1Req   & ~dl1Q);
      pendD2 <= (pendD2 & ~clrD2) | (dl2Req   & ~dl2Q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dataOut   <= 8'h2D;
      activeCam <= 2'd0;
    end else begin
      state     <= nextState;
      dataOut   <= nextData;
      activeCam <= nextCam;
    end
  end

  // The byte and the active camera are latched as the FSM leaves IDLE, so dataOut is
  // already stable when load first goes low.
  always_comb begin
    nextState = state;
    nextData  = dataOut;
    nextCam   = activeCam;
    clrS      = 1'b0;
    clrD1     = 1'b0;
    clrD2     = 1'b0;
    load      = 1'b1;
    transmit  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (pendS) begin
          nextState = LOAD;
          nextData  = CHAR_START;
          clrS      = 1'b1;
        end else if (pendD1) begin
          nextState = LOAD;
          nextData  = CHAR_DL1;
          nextCam   = 2'd1;
          clrD1     = 1'b1;
        end else if (pendD2) begin
          nextState = LOAD;
          nextData  = CHAR_DL2;
          nextCam   = 2'd2;
          clrD2     = 1'b1;
        end
      end
      LOAD: begin
        load      = 1'b0;
        nextState = SEND;
      end
      SEND: begin
        load     = 1'b0;
        transmit = 1'b1;
        if (bicS == 4'd1) nextState = DRAIN;
      end
      DRAIN: begin
        if (bicS == 4'd0) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign isDigit = (dataIn >= 8'h30) && (dataIn <= 8'h39);
  assign isG     = (dataIn == 8'h67);
  assign isH     = (dataIn == 8'h68);
  assign isDash  = (dataIn == 8'h2D);
  assign errHit  = byteStrobe &
                   ((isDigit && activeCam == 2'd0) || !(isDigit || isG || isH || isDash));

  // Receive side: one strobe per entry into bicR==9, decoded a cycle later.
  // For ASCII digits the low nibble already equals the digit value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fullQ      <= 1'b0;
      byteStrobe <= 1'b0;
      rtd1       <= 1'b0;
      rtd2       <= 1'b0;
      rxErr      <= 1'b0;
      progress1  <= 4'd0;
      progress2  <= 4'd0;
      errCount   <= 4'd0;
    end else begin
      fullQ      <= (bicR == 4'd9);
      byteStrobe <= (bicR == 4'd9) && !fullQ;
      rtd1       <= byteStrobe && isG;
      rtd2       <= byteStrobe && isH;
      rxErr      <= errHit;
      if (byteStrobe && isDigit && activeCam == 2'd1) progress1 <= dataIn[3:0];
      if (byteStrobe && isDigit && activeCam == 2'd2) progress2 <= dataIn[3:0];
      if (errHit && errCount != 4'd15) errCount <= errCount + 4'd1;
    end
  end

endmodule
